add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 in_valid  input  1  operand set present.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 a, b  input  W  operands, sampled only on acceptance.
REQ-007 cin  input  1  carry-in, sampled only on acceptance.
REQ-008 abort  input  1  synchronous cancel of the current operation.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  W  registered sum.
REQ-012 cout  output  1  unsigned carry-out of the full W-bit add.
REQ-013 ovf  output  1  two's-complement overflow of the W-bit add.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 One shared 4-bit adder slice (a4, b4, ci -> s4, co) performs all arithmetic; one slice per RUN cycle, least-significant first.
REQ-016 States: IDLE, RUN, DONE; in_ready = (state == IDLE) and not abort; out_valid = (state == DONE).
REQ-017 IDLE: on in_valid and in_ready, latch a, b; carry reg <= cin; idx <= 0; sum reg <= 0; next state RUN.
REQ-018 RUN: sum[4*idx+3 : 4*idx] <= slice s4; carry reg <= slice co; idx <= idx+1; when idx == NIBBLES-1, next state DONE.
REQ-019 Latency: out_valid rises NIBBLES clock edges after the acceptance edge (4 for default), independent of operand values.
REQ-020 DONE: sum, cout, ovf are held stable until the edge where out_ready is high; then next state IDLE.
REQ-021 cout = final carry reg; ovf = (a[W-1] == b[W-1]) and (sum[W-1] != a[W-1]), evaluated from latched operands.
REQ-022 Operands and cin changing while busy have no effect on the result.
REQ-023 abort in any state: next state IDLE, idx <= 0, no result produced; abort has priority over in_valid and out_ready in the same cycle.
REQ-024 Back-to-back: acceptance is not possible in the DONE-to-IDLE handoff cycle; new operands are accepted at the earliest one cycle after out_valid falls.
REQ-025 idx is clog2(NIBBLES) bits wide (minimum 1); no wrap beyond NIBBLES-1 occurs.

Reset
REQ-026 While rst is high: state IDLE, idx 0, carry reg 0, sum 0, latched operands 0; outputs in_ready 1, out_valid 0, busy 0, cout 0, ovf 0.
REQ-027 rst asserted mid-RUN or in DONE discards the operation immediately (asynchronously); first acceptance possible on the first rising edge after rst deasserts.

Structure
REQ-028 Shared package add_seq_pkg holds the state enumeration (IDLE, RUN, DONE) and constant SLICE_W = 4.
REQ-029 The 4-bit slice is a separate combinational sub-module adder4_slice instantiated exactly once; all sequencing stays in add_seq_ctrl.

Verification
REQ-030 a=0xFFFF, b=0xFFFF, cin=0 -> after 4 cycles sum=0xFFFE, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x000F, b=0x0000, cin=1 -> sum=0x0010 (carry across slice boundary), cout=0, ovf=0.
REQ-032 Backpressure: out_ready held low 3 cycles in DONE -> out_valid, sum, cout, ovf unchanged; in_ready stays 0; out_ready high -> IDLE next edge.
REQ-033 abort asserted in 2nd RUN cycle with in_valid high -> IDLE, out_valid never rises, no acceptance that cycle; next operands 0x1234+0x1111 -> sum=0x2345.
REQ-034 rst pulsed mid-RUN -> all outputs at REQ-026 values while rst high; following transaction 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-035 Operands toggled every cycle during RUN -> result matches operands latched at acceptance.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Holds the controller state encoding and the slice width.
package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4_slice.sv
// Combinational 4-bit adder slice with carry in/out; the controller
// reuses a single instance of it for every nibble of the operands.
module adder4_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               ci,
    output logic [SLICE_W-1:0] s4,
    output logic               co
);

    assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial W-bit adder: latches operands, then walks one shared 4-bit
// slice from LSB to MSB, one nibble per RUN cycle, and hands off the result.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       cin,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                       cout,
    output logic                       ovf,
    output logic                       busy
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               carry_reg, carry_next;
    logic [W-1:0]       sum_reg, sum_next;
    logic [W-1:0]       a_reg, a_next;
    logic [W-1:0]       b_reg, b_next;

    logic [SLICE_W-1:0] a_nibs [NIBBLES];
    logic [SLICE_W-1:0] b_nibs [NIBBLES];
    logic [W-1:0]       sum_upd;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_co;
    logic               accept;

    // Split latched operands into nibbles and merge the slice result back
    // into whichever nibble idx currently points at.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_nibs[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign sum_upd[gi*SLICE_W +: SLICE_W] =
                (idx_reg == IDX_W'(gi)) ? slice_s : sum_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_a = a_nibs[idx_reg];
    assign slice_b = b_nibs[idx_reg];

    adder4_slice u_slice (
        .a4 (slice_a),
        .b4 (slice_b),
        .ci (carry_reg),
        .s4 (slice_s),
        .co (slice_co)
    );

    assign in_ready  = (state_reg == IDLE) && !abort;
    assign accept    = in_ready && in_valid;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign cout      = carry_reg;
    assign ovf       = (a_reg[W-1] == b_reg[W-1]) && (sum_reg[W-1] != a_reg[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            sum_reg   <= sum_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        sum_next   = sum_reg;
        a_next     = a_reg;
        b_next     = b_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    sum_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                sum_next   = sum_upd;
                carry_next = slice_co;
                // idx parks on the last nibble rather than wrapping.
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next = IDLE;
            idx_next   = '0;
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: a table of operand/result vectors plus
// hand-written sequences for backpressure, abort, reset and handoff timing.
module tb_add_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept at the next posedge, scramble operands during RUN, check latency,
    // result, then release with out_ready. Called and returns just after a negedge.
    task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo);
        int cnt;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        cin       = tc;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            a   = 16'($urandom());
            b   = 16'($urandom());
            cin = 1'($urandom());
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(NIBBLES));
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        $display("txn a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
                 ta, tb_, tc, sum, cout, ovf, es, ec, eo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc;
        logic        ho;
        int          cnt;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[9]  = '{16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0};
        vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
        end

        // Backpressure in DONE, then handoff with in_valid already high.
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h0F01;
        cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_latency", 32'(cnt), 32'(NIBBLES));
        hs = sum;
        hc = cout;
        ho = ovf;
        chk("bp_sum", 32'(hs), 32'h1000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_sum_hold", 32'(sum), 32'(hs));
            chk("bp_cout_hold", 32'(cout), 32'(hc));
            chk("bp_ovf_hold", 32'(ovf), 32'(ho));
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        $display("backpressure held sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 16'h0101;
        b = 16'h0202;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
        chk("handoff_no_accept", 32'(busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("handoff_accept_next", 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("handoff_sum", 32'(sum), 32'h0303);
        $display("handoff txn sum=%h", sum);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Abort in the second RUN cycle while a new operand set is offered.
        in_valid = 1'b1;
        a = 16'h5555;
        b = 16'hAAAA;
        @(negedge clk);
        a = 16'h1111;
        b = 16'h2222;
        @(negedge clk);
        abort = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_result", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        $display("abort txn busy=%0d out_valid=%0d", busy, out_valid);
        do_txn(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN.
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_sum", 32'(sum), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        chk("mrst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        chk("mrst_hold_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-run reset released");
        do_txn(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
